// File: rtl/lut_corr_bank.sv
// lut_corr_bank: N_CH parallel signed correction tables addressed by one
// sample, with a RUN/LOAD state machine guarding host writes/readback.
// Optional feature macro: LUT_SAT_EN (saturating narrow + sticky sat_flag).

// One correction table: single write port, one registered read port.
// Contents are deliberately not reset so they survive rst_n.
module lut_corr_ram #(
   parameter int AW = 13,
   parameter int DW = 28
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata_q
);
   logic [DW-1:0] mem [2**AW];

   // write port and registered read port
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata_q <= mem[raddr];
   end
endmodule

module lut_corr_bank #(
   parameter int N_CH   = 4,
   parameter int ADDR_W = 13,
   parameter int DATA_W = 28,
   parameter int OUT_W  = 21,
   parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [ADDR_W-1:0]      sample,
   input  logic                   sample_valid,
   input  logic                   lut_cond,
   output logic [N_CH*OUT_W-1:0]  out_data,
   output logic                   out_valid,
   output logic [N_CH-1:0]        sat_flag,
   input  logic                   load_start,
   input  logic                   load_done,
   output logic                   loading,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [CH_W-1:0]        wr_ch,
   input  logic [ADDR_W-1:0]      wr_addr,
   input  logic [DATA_W-1:0]      wr_data,
   input  logic                   rd_req,
   input  logic [CH_W-1:0]        rd_ch,
   input  logic [ADDR_W-1:0]      rd_addr,
   output logic                   rd_valid,
   output logic [DATA_W-1:0]      rd_data
);
   typedef enum logic {S_RUN, S_LOAD} state_t;

   state_t state_q;
   logic   loading_q;

   logic samp_acc, wr_fire, rd_acc, ld_clr, upd;

   logic [1:0]                      vld_pipe_q, vld_pipe_d;
   logic [1:0]                      cond_pipe_q, cond_pipe_d;
   logic [ADDR_W-1:0]               samp_addr_q, samp_addr_d;
   logic [1:0]                      rd_pipe_q, rd_pipe_d;
   logic [ADDR_W-1:0]               rd_addr_q, rd_addr_d;
   logic [CH_W-1:0]                 rd_ch_q, rd_ch_d;
   logic [CH_W-1:0]                 rd_ch2_q, rd_ch2_d;
   logic [N_CH-1:0][OUT_W-1:0]      out_data_q, out_data_d;
   logic                            out_valid_q, out_valid_d;
   logic [N_CH-1:0]                 sat_q, sat_d;
   logic                            rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0]               rd_data_q, rd_data_d;

   logic [N_CH-1:0][DATA_W-1:0]     ram_rdata;
   logic [ADDR_W-1:0]               ram_raddr;
   logic [N_CH-1:0][OUT_W-1:0]      nar;
   logic [N_CH-1:0]                 nsat;
   logic [DATA_W-1:0]               rd_sel;
`ifdef LUT_SAT_EN
   logic [DATA_W-OUT_W:0]           hi;
`endif

   assign samp_acc = sample_valid & ~loading_q;
   assign wr_fire  = wr_valid & loading_q;
   assign rd_acc   = rd_req & loading_q & ~wr_valid;   // a colliding write wins
   assign ld_clr   = load_start & ~loading_q;
   assign upd      = vld_pipe_q[1] & cond_pipe_q[1];

   // Lookups and readbacks never need the read port in the same cycle:
   // readbacks are only issued in LOAD, and a sample's RAM read always
   // lands at least one cycle away from any readback's RAM read.
   assign ram_raddr = rd_pipe_q[0] ? rd_addr_q : samp_addr_q;

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      lut_corr_ram #(.AW(ADDR_W), .DW(DATA_W)) u_ram (
         .clk     (clk),
         .we      (wr_fire && (wr_ch == CH_W'(k))),
         .waddr   (wr_addr),
         .wdata   (wr_data),
         .raddr   (ram_raddr),
         .rdata_q (ram_rdata[k])
      );
   end

   // RUN/LOAD sequencing; loading doubles as wr_ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_RUN;
         loading_q <= 1'b0;
      end else begin
         case (state_q)
            S_RUN:  if (load_start) begin state_q <= S_LOAD; loading_q <= 1'b1; end
            S_LOAD: if (load_done)  begin state_q <= S_RUN;  loading_q <= 1'b0; end
            default: begin state_q <= S_RUN; loading_q <= 1'b0; end
         endcase
      end
   end

   // narrow each table word to OUT_W and pick the readback channel
   always_comb begin
      nar    = '0;
      nsat   = '0;
      rd_sel = '0;
`ifdef LUT_SAT_EN
      hi     = '0;
`endif
      for (int k = 0; k < N_CH; k++) begin
`ifdef LUT_SAT_EN
         hi = ram_rdata[k][DATA_W-1:OUT_W-1];
         if (!((&hi) || !(|hi))) begin
            nsat[k] = 1'b1;
            nar[k]  = ram_rdata[k][DATA_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                              : {1'b0, {(OUT_W-1){1'b1}}};
         end else begin
            nar[k]  = ram_rdata[k][OUT_W-1:0];
         end
`else
         nar[k] = ram_rdata[k][OUT_W-1:0];
`endif
         if (rd_ch2_q == CH_W'(k)) rd_sel = ram_rdata[k];   // out-of-range channel reads 0
      end
   end

   // next-state for lookup and readback pipelines
   always_comb begin
      vld_pipe_d  = {vld_pipe_q[0], samp_acc};
      cond_pipe_d = {cond_pipe_q[0], lut_cond};
      samp_addr_d = samp_acc ? sample : samp_addr_q;
      rd_pipe_d   = {rd_pipe_q[0], rd_acc};
      rd_addr_d   = rd_acc ? rd_addr : rd_addr_q;
      rd_ch_d     = rd_acc ? rd_ch : rd_ch_q;
      rd_ch2_d    = rd_ch_q;
      out_valid_d = upd;
      out_data_d  = upd ? nar : out_data_q;
      sat_d       = ld_clr ? '0 : sat_q;
      if (upd) sat_d = sat_d | nsat;
      rd_valid_d  = rd_pipe_q[1];
      rd_data_d   = rd_pipe_q[1] ? rd_sel : rd_data_q;
   end

   // pipeline and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe_q  <= '0;
         cond_pipe_q <= '0;
         samp_addr_q <= '0;
         rd_pipe_q   <= '0;
         rd_addr_q   <= '0;
         rd_ch_q     <= '0;
         rd_ch2_q    <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         sat_q       <= '0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         vld_pipe_q  <= vld_pipe_d;
         cond_pipe_q <= cond_pipe_d;
         samp_addr_q <= samp_addr_d;
         rd_pipe_q   <= rd_pipe_d;
         rd_addr_q   <= rd_addr_d;
         rd_ch_q     <= rd_ch_d;
         rd_ch2_q    <= rd_ch2_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         sat_q       <= sat_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign sat_flag  = sat_q;
   assign loading   = loading_q;
   assign wr_ready  = loading_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
endmodule
